// File: rtl/it8951_cmd_sequencer.sv
// IT8951 command sequencer: walks the generator index, gates each word on HRDY and hands it to the word engine.
// Per-word overhead CHECK+WAIT_HRDY+ISSUE+WAIT_DONE; word_valid holds until word_ready, read-back captured on word_done.
module it8951_cmd_sequencer #(
  parameter int HRDY_TIMEOUT = 2000000,
  parameter int REP_W        = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seq_start,
  input  logic [7:0]       seq_select,
  input  logic [REP_W-1:0] seq_repeat,
  output logic             seq_busy,
  output logic             seq_done,
  output logic             seq_error,
  output logic [7:0]       command_select,
  output logic [7:0]       command_index,
  input  logic [16:0]      command,
  input  logic             command_done,
  output logic             pixel_advance,
  output logic             word_valid,
  output logic [15:0]      word_data,
  output logic             word_release_cs,
  input  logic             word_ready,
  input  logic             word_done,
  input  logic [15:0]      word_rdata,
  input  logic             cs_active,
  input  logic             hrdy,
  output logic [15:0]      rdata,
  output logic             rdata_valid
);

  localparam int TMO_W = $clog2(HRDY_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHECK     = 3'd1;
  localparam logic [2:0] S_WAIT_HRDY = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;

  typedef struct packed {
    logic        release_cs;
    logic [15:0] dat;
  } word_t;

  logic [2:0]       state_q, state_d;
  logic [7:0]       sel_q, sel_d;
  logic [7:0]       idx_q, idx_d;
  logic [REP_W-1:0] rep_q, rep_d, rep_dec;
  word_t            word_q, word_d;
  logic             word_vld_q, word_vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             pix_q, pix_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             rdata_vld_q, rdata_vld_d;
  logic             rd_phase_q, rd_phase_d;
  logic             dummy_q, dummy_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic             cs_hold_q, cs_hold_d;
  logic             hrdy_meta_q, hrdy_sync_q;

  assign rep_dec = rep_q - REP_W'(1);
  assign tmo_inc = tmo_q + TMO_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hrdy_meta_q <= 1'b0;
      hrdy_sync_q <= 1'b0;
    end else begin
      hrdy_meta_q <= hrdy;
      hrdy_sync_q <= hrdy_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    rep_d       = rep_q;
    word_d      = word_q;
    word_vld_d  = word_vld_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    pix_d       = 1'b0;
    rdata_d     = rdata_q;
    rdata_vld_d = 1'b0;
    rd_phase_d  = rd_phase_q;
    dummy_d     = dummy_q;
    tmo_d       = '0;
    cs_hold_d   = cs_hold_q & cs_active;

    case (state_q)
      S_IDLE: begin
        // After a timeout with CS still held, the engine must recover CS before new words go out.
        if (seq_start && !cs_hold_q) begin
          sel_d   = seq_select;
          idx_d   = 8'd0;
          rep_d   = (seq_repeat == '0) ? REP_W'(1) : seq_repeat;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (command_done) begin
          rep_d = rep_dec;
          idx_d = 8'd0;
          if (rep_dec == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end
        end else begin
          word_d  = word_t'(command);
          state_d = S_WAIT_HRDY;
        end
      end
      S_WAIT_HRDY: begin
        if (hrdy_sync_q) begin
          word_vld_d = 1'b1;
          state_d    = S_ISSUE;
        end else if (tmo_inc == TMO_W'(HRDY_TIMEOUT)) begin
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_ISSUE: begin
        if (word_ready) begin
          word_vld_d = 1'b0;
          state_d    = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (word_done) begin
          // 0x1000 opens a read phase; the first word after it is the IT8951 dummy read.
          if (!rd_phase_q) begin
            if (word_q.dat == 16'h1000 && !word_q.release_cs) begin
              rd_phase_d = 1'b1;
              dummy_d    = 1'b1;
            end
          end else if (dummy_q) begin
            dummy_d = 1'b0;
            if (word_q.release_cs) rd_phase_d = 1'b0;
          end else begin
            rdata_d     = word_rdata;
            rdata_vld_d = 1'b1;
            if (word_q.release_cs) rd_phase_d = 1'b0;
          end
          pix_d   = (sel_q == 8'd5) && (idx_q == 8'd1);
          idx_d   = idx_q + 8'd1;
          state_d = S_CHECK;
        end
      end
      S_FINISH: begin
        rd_phase_d = 1'b0;
        dummy_d    = 1'b0;
        if (err_q && cs_active) cs_hold_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d     = 1'b0;
        word_vld_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= 8'd0;
      idx_q       <= 8'd0;
      rep_q       <= '0;
      word_q      <= '0;
      word_vld_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pix_q       <= 1'b0;
      rdata_q     <= 16'd0;
      rdata_vld_q <= 1'b0;
      rd_phase_q  <= 1'b0;
      dummy_q     <= 1'b0;
      tmo_q       <= '0;
      cs_hold_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      rep_q       <= rep_d;
      word_q      <= word_d;
      word_vld_q  <= word_vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pix_q       <= pix_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      rd_phase_q  <= rd_phase_d;
      dummy_q     <= dummy_d;
      tmo_q       <= tmo_d;
      cs_hold_q   <= cs_hold_d;
    end
  end

  assign seq_busy        = busy_q;
  assign seq_done        = done_q;
  assign seq_error       = err_q;
  assign command_select  = sel_q;
  assign command_index   = idx_q;
  assign pixel_advance   = pix_q;
  assign word_valid      = word_vld_q;
  assign word_data       = word_q.dat;
  assign word_release_cs = word_q.release_cs;
  assign rdata           = rdata_q;
  assign rdata_valid     = rdata_vld_q;

endmodule
